// File: rtl/cci_mpf_shim_vtp_pkg.sv
// cci_mpf_shim_vtp_pkg: shared VTP page-index type, pending-walk entry and 2MB index helper
package cci_mpf_shim_vtp_pkg;
  localparam int VTP_VA_PAGE_BITS = 36;
  typedef logic [VTP_VA_PAGE_BITS-1:0] t_tlb_4kb_va_page_idx;
  typedef struct packed {
    logic                 valid;
    t_tlb_4kb_va_page_idx va;
  } t_pending_entry;
  function automatic t_tlb_4kb_va_page_idx vtp_4kb_to_2mb_idx(t_tlb_4kb_va_page_idx va, int shift);
    return va >> shift;
  endfunction
endpackage

// File: rtl/cci_mpf_shim_vtp_pending_cam.sv
// cci_mpf_shim_vtp_pending_cam: in-flight walk table with per-channel match, one alloc and a 4KB/2MB free port
module cci_mpf_shim_vtp_pending_cam
  import cci_mpf_shim_vtp_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int N_MATCH   = 2,
  parameter int BIG_SHIFT = 9
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  t_tlb_4kb_va_page_idx [N_MATCH-1:0]  match_va,
  output logic [N_MATCH-1:0]                  match_hit,
  input  logic                                alloc_en,
  input  t_tlb_4kb_va_page_idx                alloc_va,
  input  logic                                free_en,
  input  logic                                free_big,
  input  t_tlb_4kb_va_page_idx                free_va,
  output logic                                free_hit,
  output logic                                full
);
  t_pending_entry [N_ENTRIES-1:0] ent_q, ent_d;
  logic full_q, full_d;
  logic [N_ENTRIES-1:0] clr, alloc_sel;
  // Matching and free-slot search both look only at registered state.
  always_comb begin
    logic taken;
    taken = 1'b0;
    match_hit = '0;
    clr = '0;
    alloc_sel = '0;
    for (int c = 0; c < N_MATCH; c++)
      for (int i = 0; i < N_ENTRIES; i++)
        if (ent_q[i].valid && ent_q[i].va == match_va[c]) match_hit[c] = 1'b1;
    for (int i = 0; i < N_ENTRIES; i++) begin
      clr[i] = free_en && ent_q[i].valid &&
               (free_big ? vtp_4kb_to_2mb_idx(ent_q[i].va, BIG_SHIFT) == vtp_4kb_to_2mb_idx(free_va, BIG_SHIFT)
                         : ent_q[i].va == free_va);
      if (alloc_en && !taken && !ent_q[i].valid) begin
        alloc_sel[i] = 1'b1;
        taken = 1'b1;
      end
    end
    free_hit = |clr;
    ent_d = ent_q;
    full_d = 1'b1;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (clr[i]) ent_d[i].valid = 1'b0;
      if (alloc_sel[i]) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].va = alloc_va;
      end
      full_d = full_d & ent_d[i].valid;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q <= '0;
      full_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      full_q <= full_d;
    end
  end
  assign full = full_q;
endmodule

// File: rtl/cci_mpf_shim_vtp_walk_arb.sv
// cci_mpf_shim_vtp_walk_arb: round-robin TLB-miss arbiter to the page walker with in-flight dedup
// Optional counters enabled by defining VTP_WALK_ARB_STATS_EN.
module cci_mpf_shim_vtp_walk_arb
  import cci_mpf_shim_vtp_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int VA_PAGE_BITS   = 36,
  parameter int MAX_PENDING    = 4,
  parameter int BIG_PAGE_SHIFT = 9,
  localparam int CHAN_BITS     = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_CHANNELS-1:0]                  miss_en,
  input  logic [NUM_CHANNELS-1:0][VA_PAGE_BITS-1:0] miss_va,
  input  logic                                     fill_rdy,
  output logic                                     walk_req_en,
  output logic [VA_PAGE_BITS-1:0]                  walk_req_va,
  output logic [CHAN_BITS-1:0]                     walk_req_chan,
  input  logic                                     walk_req_rdy,
  input  logic                                     walk_done_en,
  input  logic [VA_PAGE_BITS-1:0]                  walk_done_va,
  input  logic                                     walk_done_big_page,
  output logic                                     pending_full,
  output logic                                     err_orphan_done,
  output logic [31:0]                              stat_grants,
  output logic [31:0]                              stat_dup_suppressed
);
  t_tlb_4kb_va_page_idx [NUM_CHANNELS-1:0] cam_va;
  logic [NUM_CHANNELS-1:0] hit, elig;
  logic free_hit, grant;
  logic [CHAN_BITS-1:0] win, rr_q, rr_d, chan_q, chan_d;
  logic [VA_PAGE_BITS-1:0] va_q, va_d;
  logic en_q, en_d, err_q, err_d;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_va
    assign cam_va[c] = t_tlb_4kb_va_page_idx'(miss_va[c]);
  end
  cci_mpf_shim_vtp_pending_cam #(
    .N_ENTRIES(MAX_PENDING), .N_MATCH(NUM_CHANNELS), .BIG_SHIFT(BIG_PAGE_SHIFT)
  ) u_cam (
    .clk(clk), .reset_n(reset_n),
    .match_va(cam_va), .match_hit(hit),
    .alloc_en(grant), .alloc_va(t_tlb_4kb_va_page_idx'(va_d)),
    .free_en(walk_done_en), .free_big(walk_done_big_page),
    .free_va(t_tlb_4kb_va_page_idx'(walk_done_va)),
    .free_hit(free_hit), .full(pending_full)
  );
  // Scan descending so the channel nearest rr_q+1 is assigned last and wins.
  always_comb begin
    int idx;
    idx = 0;
    elig = miss_en & ~hit & {NUM_CHANNELS{~en_q & fill_rdy & ~pending_full}};
    grant = 1'b0;
    win = '0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NUM_CHANNELS;
      if (elig[idx]) begin
        grant = 1'b1;
        win = CHAN_BITS'(idx);
      end
    end
    en_d = grant | (en_q & ~walk_req_rdy);
    va_d = grant ? miss_va[win] : va_q;
    chan_d = grant ? win : chan_q;
    rr_d = grant ? win : rr_q;
    err_d = err_q | (walk_done_en & ~free_hit);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
      va_q <= '0;
      chan_q <= '0;
      rr_q <= CHAN_BITS'(NUM_CHANNELS - 1);
      err_q <= 1'b0;
    end else begin
      en_q <= en_d;
      va_q <= va_d;
      chan_q <= chan_d;
      rr_q <= rr_d;
      err_q <= err_d;
    end
  end
  assign walk_req_en = en_q;
  assign walk_req_va = va_q;
  assign walk_req_chan = chan_q;
  assign err_orphan_done = err_q;
`ifdef VTP_WALK_ARB_STATS_EN
  logic [31:0] grants_q, dup_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grants_q <= '0;
      dup_q <= '0;
    end else begin
      grants_q <= grants_q + 32'(grant && grants_q != '1);
      dup_q <= dup_q + 32'((|(miss_en & hit)) && dup_q != '1);
    end
  end
  assign stat_grants = grants_q;
  assign stat_dup_suppressed = dup_q;
`else
  assign stat_grants = '0;
  assign stat_dup_suppressed = '0;
`endif
endmodule

// File: tb/tb_cci_mpf_shim_vtp_walk_arb.sv
// tb_cci_mpf_shim_vtp_walk_arb: directed scenarios plus randomized run against a queue-based reference model
module tb_cci_mpf_shim_vtp_walk_arb;
  localparam int NC = 2, VB = 36, MP = 4, SH = 9;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [NC-1:0] miss_en;
  logic [NC-1:0][VB-1:0] miss_va;
  logic fill_rdy, walk_req_rdy, walk_done_en, walk_done_big_page;
  logic [VB-1:0] walk_done_va, walk_req_va;
  logic walk_req_en, pending_full, err_orphan_done;
  logic [0:0] walk_req_chan;
  logic [31:0] stat_grants, stat_dup_suppressed;
  int checks = 0, errors = 0;
  // Reference model: the table is just a set of pending VAs.
  logic [VB-1:0] pend[$];
  bit m_en, m_full, m_err;
  logic [VB-1:0] m_va;
  int m_chan, m_rr, m_grants, m_dup;
  logic [VB-1:0] pool [6] = '{36'h10, 36'h11, 36'h13, 36'h200, 36'h3FF, 36'h400};

  cci_mpf_shim_vtp_walk_arb #(.NUM_CHANNELS(NC), .VA_PAGE_BITS(VB), .MAX_PENDING(MP), .BIG_PAGE_SHIFT(SH)) dut (
    .clk(clk), .reset_n(reset_n), .miss_en(miss_en), .miss_va(miss_va), .fill_rdy(fill_rdy),
    .walk_req_en(walk_req_en), .walk_req_va(walk_req_va), .walk_req_chan(walk_req_chan),
    .walk_req_rdy(walk_req_rdy), .walk_done_en(walk_done_en), .walk_done_va(walk_done_va),
    .walk_done_big_page(walk_done_big_page), .pending_full(pending_full),
    .err_orphan_done(err_orphan_done), .stat_grants(stat_grants), .stat_dup_suppressed(stat_dup_suppressed));

  always #5 clk = ~clk;

  function automatic void model_reset();
    pend.delete();
    m_en = 0; m_full = 0; m_err = 0; m_va = '0; m_chan = 0; m_rr = NC - 1; m_grants = 0; m_dup = 0;
  endfunction

  function automatic void model_step();
    bit hit [NC];
    bit dup;
    int win, n;
    logic [VB-1:0] keep[$];
    win = -1; dup = 0;
    for (int c = 0; c < NC; c++) begin
      hit[c] = 0;
      foreach (pend[i]) if (pend[i] == miss_va[c]) hit[c] = 1;
      if (miss_en[c] && hit[c]) dup = 1;
    end
    if (!m_en && fill_rdy && pend.size() < MP)
      for (int k = 1; k <= NC; k++) begin
        int c;
        c = (m_rr + k) % NC;
        if (win < 0 && miss_en[c] && !hit[c]) win = c;
      end
    if (walk_done_en) begin
      n = pend.size();
      foreach (pend[i])
        if (walk_done_big_page ? (pend[i] >> SH) != (walk_done_va >> SH) : pend[i] != walk_done_va) keep.push_back(pend[i]);
      pend = keep;
      if (pend.size() == n) m_err = 1;
    end
    if (m_en && walk_req_rdy) m_en = 0;
    if (win >= 0) begin
      m_en = 1; m_va = miss_va[win]; m_chan = win; m_rr = win; m_grants++;
      pend.push_back(miss_va[win]);
    end
    if (dup) m_dup++;
    m_full = pend.size() == MP;
  endfunction

  task automatic idle();
    miss_en = '0; miss_va = '0; fill_rdy = 1; walk_req_rdy = 0;
    walk_done_en = 0; walk_done_va = '0; walk_done_big_page = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (walk_req_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", walk_req_en); end
    if (walk_req_va !== '0) begin errors++; $display("FAIL reset_va got %0h want 0", walk_req_va); end
    if (walk_req_chan !== 1'b0) begin errors++; $display("FAIL reset_chan got %0d want 0", walk_req_chan); end
    if (pending_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", pending_full); end
    if (err_orphan_done !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_orphan_done); end
    if (stat_grants !== 32'd0 || stat_dup_suppressed !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_grants, stat_dup_suppressed); end
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    miss_en = 2'b01; miss_va[0] = 36'h123;
    cycle();
    checks++;
    if (walk_req_en !== 1 || walk_req_va !== 36'h123 || walk_req_chan !== 0) begin errors++; $display("FAIL basic_grant got en=%0b va=%0h ch=%0d want 1/123/0", walk_req_en, walk_req_va, walk_req_chan); end
    miss_en = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (walk_req_en !== 1 || walk_req_va !== 36'h123 || walk_req_chan !== 0) begin errors++; $display("FAIL basic_hold got en=%0b va=%0h ch=%0d want 1/123/0", walk_req_en, walk_req_va, walk_req_chan); end
    end
    walk_req_rdy = 1;
    cycle();
    checks++;
    if (walk_req_en !== 0) begin errors++; $display("FAIL basic_drop got en=%0b want 0", walk_req_en); end
    idle();
  endtask

  task automatic test_round_robin();
    int chans[$], dq_t[$];
    logic [VB-1:0] dq_va[$];
    do_reset();
    miss_en = 2'b11; miss_va[0] = 36'h10; miss_va[1] = 36'h20; walk_req_rdy = 1;
    for (int t = 0; t < 80 && chans.size() < 4; t++) begin
      walk_done_en = 0;
      if (dq_t.size() > 0 && dq_t[0] <= t) begin
        walk_done_en = 1; walk_done_va = dq_va.pop_front(); void'(dq_t.pop_front());
      end
      cycle();
      if (walk_req_en) begin chans.push_back(int'(walk_req_chan)); dq_va.push_back(walk_req_va); dq_t.push_back(t + 3); end
    end
    checks++;
    if (chans.size() != 4) begin errors++; $display("FAIL rr_count got %0d want 4", chans.size()); end
    foreach (chans[i]) begin
      checks++;
      if (chans[i] != i % 2) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, chans[i], i % 2); end
    end
    idle();
  endtask

  task automatic test_dedup();
    int n;
    do_reset();
    n = 0;
    miss_en = 2'b11; miss_va[0] = 36'h55; miss_va[1] = 36'h55; walk_req_rdy = 1;
    repeat (20) begin cycle(); if (walk_req_en) n++; end
    checks++;
    if (n != 1) begin errors++; $display("FAIL dedup_grants got %0d want 1", n); end
    checks++;
`ifdef VTP_WALK_ARB_STATS_EN
    if (stat_grants !== 32'd1 || stat_dup_suppressed < 32'd18) begin errors++; $display("FAIL dedup_stats got %0d/%0d want 1/>=18", stat_grants, stat_dup_suppressed); end
`else
    if (stat_grants !== 32'd0 || stat_dup_suppressed !== 32'd0) begin errors++; $display("FAIL dedup_stats got %0d/%0d want 0/0", stat_grants, stat_dup_suppressed); end
`endif
    idle();
  endtask

  task automatic test_big_page();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      miss_en = 2'b01; miss_va[0] = i == 0 ? 36'h200 : 36'h3FF;
      cycle();
      miss_en = '0; walk_req_rdy = 1;
      cycle();
      walk_req_rdy = 0;
    end
    miss_en = 2'b01; miss_va[0] = 36'h3FF;
    cycle();
    checks++;
    if (walk_req_en !== 0) begin errors++; $display("FAIL big_suppress got en=%0b want 0", walk_req_en); end
    miss_en = '0; walk_done_en = 1; walk_done_va = 36'h200; walk_done_big_page = 1;
    cycle();
    walk_done_en = 0; walk_done_big_page = 0; miss_en = 2'b01;
    cycle();
    checks += 2;
    if (walk_req_en !== 1 || walk_req_va !== 36'h3FF) begin errors++; $display("FAIL big_regrant got en=%0b va=%0h want 1/3ff", walk_req_en, walk_req_va); end
    if (err_orphan_done !== 0) begin errors++; $display("FAIL big_err got %0b want 0", err_orphan_done); end
    idle();
  endtask

  task automatic test_full_orphan();
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      miss_en = 2'b01; miss_va[0] = VB'(v);
      cycle();
      checks++;
      if (walk_req_en !== 1 || walk_req_va !== VB'(v)) begin errors++; $display("FAIL full_grant%0d got en=%0b va=%0h", v, walk_req_en, walk_req_va); end
      miss_en = '0; walk_req_rdy = 1;
      cycle();
      walk_req_rdy = 0;
    end
    checks++;
    if (pending_full !== 1) begin errors++; $display("FAIL full_flag got %0b want 1", pending_full); end
    miss_en = 2'b01; miss_va[0] = 36'h5;
    repeat (3) begin
      cycle();
      checks++;
      if (walk_req_en !== 0) begin errors++; $display("FAIL full_block got en=%0b want 0", walk_req_en); end
    end
    miss_en = '0; walk_done_en = 1; walk_done_va = 36'h999;
    cycle();
    checks++;
    if (err_orphan_done !== 1 || pending_full !== 1) begin errors++; $display("FAIL orphan got err=%0b full=%0b want 1/1", err_orphan_done, pending_full); end
    walk_done_en = 0;
    repeat (3) cycle();
    walk_done_en = 1; walk_done_va = 36'h1;
    cycle();
    walk_done_en = 0;
    checks++;
    if (err_orphan_done !== 1 || pending_full !== 0) begin errors++; $display("FAIL orphan_sticky got err=%0b full=%0b want 1/0", err_orphan_done, pending_full); end
  endtask

  task automatic test_reset_mid();
    idle();
    miss_en = 2'b01; miss_va[0] = 36'h77;
    cycle();
    checks++;
    if (walk_req_en !== 1) begin errors++; $display("FAIL mid_pre got en=%0b want 1", walk_req_en); end
    miss_en = '0;
    #2 reset_n = 0;
    #1;
    checks++;
    if (walk_req_en !== 0 || walk_req_va !== '0 || walk_req_chan !== 0 || pending_full !== 0 || err_orphan_done !== 0) begin
      errors++; $display("FAIL mid_async got en=%0b va=%0h ch=%0d full=%0b err=%0b want all 0", walk_req_en, walk_req_va, walk_req_chan, pending_full, err_orphan_done);
    end
    @(posedge clk);
    #1 reset_n = 1;
    model_reset();
    miss_en = 2'b11; miss_va[0] = 36'h2; miss_va[1] = 36'h3;
    cycle();
    checks++;
    if (walk_req_en !== 1 || walk_req_chan !== 0 || walk_req_va !== 36'h2) begin errors++; $display("FAIL mid_first got en=%0b ch=%0d va=%0h want 1/0/2", walk_req_en, walk_req_chan, walk_req_va); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 600; t++) begin
      int r;
      miss_en = NC'($urandom);
      for (int c = 0; c < NC; c++) miss_va[c] = pool[$urandom_range(5)];
      fill_rdy = ($urandom % 8) != 0;
      walk_req_rdy = $urandom % 2;
      r = $urandom % 16;
      walk_done_en = 0; walk_done_big_page = 0;
      if (r < 4 && pend.size() > 0) begin
        walk_done_en = 1; walk_done_va = pend[$urandom_range(pend.size() - 1)]; walk_done_big_page = ($urandom % 3) == 0;
      end else if (r == 4 && t > 400) begin
        walk_done_en = 1; walk_done_va = 36'h999;
      end
      cycle();
      checks++;
      if (walk_req_en !== m_en || pending_full !== m_full || err_orphan_done !== m_err ||
          (m_en && (walk_req_va !== m_va || walk_req_chan !== 1'(m_chan)))) begin
        errors++;
        $display("FAIL rand@%0d got en=%0b va=%0h ch=%0d full=%0b err=%0b want %0b/%0h/%0d/%0b/%0b",
                 t, walk_req_en, walk_req_va, walk_req_chan, pending_full, err_orphan_done, m_en, m_va, m_chan, m_full, m_err);
      end
    end
    checks++;
`ifdef VTP_WALK_ARB_STATS_EN
    if (stat_grants !== 32'(m_grants) || stat_dup_suppressed !== 32'(m_dup)) begin errors++; $display("FAIL rand_stats got %0d/%0d want %0d/%0d", stat_grants, stat_dup_suppressed, m_grants, m_dup); end
`else
    if (stat_grants !== 32'd0 || stat_dup_suppressed !== 32'd0) begin errors++; $display("FAIL rand_stats got %0d/%0d want 0/0", stat_grants, stat_dup_suppressed); end
`endif
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_dedup();
    test_big_page();
    test_full_orphan();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cci_mpf_shim_vtp_walk_arb.md
# cci_mpf_shim_vtp_walk_arb

- Parametrised successor of the VTP shim's fixed two-channel TLB-miss arbiter.
- Accepts per-channel TLB miss indications from NUM_CHANNELS lookup pipelines and forwards them to the page-table walker.
- Selects among channels with a round-robin grant and a held valid/ready handshake.
- Keeps a table of in-flight walks, so repeated misses to a page already being walked are suppressed. The table is cleared at 4KB or 2MB granularity on walk completion.

## Interface
Parameters:
- NUM_CHANNELS, 2: number of TLB lookup channels (≥1).
- VA_PAGE_BITS, 36: width of a 4KB virtual page index.
- MAX_PENDING, 4: depth of the in-flight walk table (≥1).
- BIG_PAGE_SHIFT, 9: 4KB-index bits dropped for 2MB-granularity match.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- miss_en  in  NUM_CHANNELS  per-channel TLB miss, level, may repeat every cycle
- miss_va  in  NUM_CHANNELS×VA_PAGE_BITS  missing 4KB page index per channel
- fill_rdy  in  1  TLB able to accept a fill
- walk_req_en  out  1  walk request valid
- walk_req_va  out  VA_PAGE_BITS  page to walk
- walk_req_chan  out  $clog2(NUM_CHANNELS) (min 1)  granted channel
- walk_req_rdy  in  1  walker accepts request
- walk_done_en  in  1  walk finished (fill issued)
- walk_done_va  in  VA_PAGE_BITS  page of completed walk
- walk_done_big_page  in  1  completion was a 2MB mapping
- pending_full  out  1  table has no free entry
- err_orphan_done  out  1  sticky: completion matched no entry
- stat_grants  out  32  grant count
- stat_dup_suppressed  out  32  suppressed-miss cycle count

## Operation
- Table entry: valid bit + VA.
- A miss on channel c is eligible when all of the following hold:
  - miss_en[c] is set;
  - miss_va[c] matches no valid table entry (exact 4KB compare);
  - walk_req_en is low and fill_rdy is high;
  - pending_full is low.
- Grant:
  - Round-robin from rr_ptr+1 upward, wrapping.
  - Grant loads walk_req_en=1, walk_req_va, walk_req_chan; allocates the lowest free entry with that VA; sets rr_ptr to the winner.
- Hold:
  - walk_req_en and its payload stay stable until a cycle where walk_req_rdy=1.
  - walk_req_en clears the following cycle.
  - No new grant while walk_req_en=1.
- Same VA on two channels in one cycle: one grant; the loser is suppressed on later cycles by the table match.
- Completion clears matching entries:
  - walk_done_big_page=0: entries equal to walk_done_va.
  - walk_done_big_page=1: all entries whose VA>>BIG_PAGE_SHIFT equals walk_done_va>>BIG_PAGE_SHIFT.
  - No match: set err_orphan_done.
- Reset mid-operation: outstanding request dropped, table cleared. The walker must be reset with the arbiter.

## Timing
- Reset values:
  - walk_req_en=0, walk_req_va=0, walk_req_chan=0;
  - table all invalid, pending_full=0;
  - rr_ptr=NUM_CHANNELS-1, so channel 0 wins first;
  - err_orphan_done=0, stats=0.
- Latency: eligible miss at cycle t → walk_req_en=1 at t+1. Entry valid at t+1.
- Eligibility and match use registered table state. An entry freed by walk_done_en at t is reusable, and no longer suppresses, from t+1.
- Completion and grant allocation in the same cycle are both performed. A slot freed in cycle t is not counted free until t+1.
- pending_full is registered, derived from the table state after each cycle's updates.
- walk_req_rdy is ignored while walk_req_en=0.

## Configuration
- VTP_WALK_ARB_STATS_EN defined:
  - stat_grants increments on each grant;
  - stat_dup_suppressed increments each cycle in which at least one channel has miss_en=1 but is blocked by a table match;
  - both counters saturate at 2^32-1.
- Undefined: both stat outputs are constant 0 and no counter flops are built.

## Structure
- Shared package cci_mpf_shim_vtp_pkg holds:
  - t_tlb_4kb_va_page_idx;
  - the 2MB-index conversion function;
  - the pending-entry struct.
- Sub-module cci_mpf_shim_vtp_pending_cam: MAX_PENDING entries; NUM_CHANNELS match ports; one alloc port; one granularity-selectable free port; full flag.
- Arbitration, handshake hold and error/stat logic live in the top.

## Test plan
- Basic grant: after reset, channel 0 misses VA 0x123 → walk_req_en at next cycle, va=0x123, chan=0. walk_req_rdy held 0 for 3 cycles keeps the payload stable; rdy=1 → en drops the next cycle.
- Round-robin: 2 channels missing continuously on VAs 0x10 and 0x20, walker always ready, completions 2 cycles after accept → grants alternate 0,1,0,1.
- Dedup: both channels miss 0x55 in the same cycle and keep missing for 20 cycles → exactly one grant; with stats enabled, stat_dup_suppressed ≥ 18.
- Big-page clear: pending 0x200 and 0x3FF, done va=0x200 with big_page=1 → both entries cleared; a new miss to 0x3FF is granted.
- Full and orphan: MAX_PENDING=4, four distinct grants with no completions → pending_full=1 and a fifth miss is not granted. walk_done_va=0x999 (no matching entry) → err_orphan_done=1 and stays 1.
- Reset mid-handshake: assert reset_n=0 while walk_req_en=1 → outputs reach their reset values immediately; after release, table is empty and channel 0 wins first.
